// File: rtl/mem_arbiter.sv
// Two-master arbiter (instruction fetch, data load/store) in front of one stalling memory.
// Data normally wins; a bounded starvation counter guarantees instruction progress.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic [15:0] i_rdata,
  output logic        i_done,
  output logic        i_stall,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_done,
  output logic        d_stall,
  output logic        m_rd,
  output logic        m_wr,
  output logic        m_dump,
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  input  logic [15:0] m_rdata,
  input  logic        m_done,
  input  logic        m_stall,
  input  logic        m_err,
  input  logic        halt,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  starve_q, starve_d;
  logic        own_data_q, own_data_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] i_rdata_q, i_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;
  logic        m_rd_q, m_rd_d;
  logic        m_wr_q, m_wr_d;
  logic        m_dump_q, m_dump_d;
  logic        i_done_q, i_done_d;
  logic        d_done_q, d_done_d;
  logic        err_q, err_d;
  logic        dumped_q, dumped_d;

  logic        d_req_s, d_bad_s, d_ok_s, starved_s, grant_i_s, grant_d_s, complete_s;

  // A simultaneous read+write is illegal and never arbitrated.
  assign d_req_s   = d_rd | d_wr;
  assign d_bad_s   = d_rd & d_wr;
  assign d_ok_s    = d_req_s & ~d_bad_s;
  assign starved_s = (starve_q == 3'(STARVE_MAX));
  assign grant_i_s = i_req & (~d_ok_s | starved_s);
  assign grant_d_s = d_ok_s & ~grant_i_s;

  // Next-state, request latching and completion handling
  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    own_data_d = own_data_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    m_rd_d     = m_rd_q;
    m_wr_d     = m_wr_q;
    m_dump_d   = 1'b0;
    i_done_d   = 1'b0;
    d_done_d   = 1'b0;
    err_d      = err_q;
    dumped_d   = dumped_q & halt;
    complete_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_bad_s) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (grant_i_s || grant_d_s) begin
          state_d    = ISSUE;
          own_data_d = grant_d_s;
          wr_d       = grant_d_s & d_wr;
          m_rd_d     = ~(grant_d_s & d_wr);
          m_wr_d     = grant_d_s & d_wr;
          if (grant_d_s) begin
            addr_d   = d_addr;
            wdata_d  = d_wdata;
            starve_d = (i_req && (starve_q != 3'd7)) ? starve_q + 3'd1 : starve_q;
          end else begin
            addr_d   = i_addr;
            wdata_d  = 16'h0000;
            starve_d = 3'd0;
          end
        end else if (halt && !i_req && !d_req_s && !dumped_q) begin
          m_dump_d = 1'b1;
          dumped_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (m_err) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (m_stall) begin
          state_d = ISSUE;
        end else if (m_done) begin
          complete_s = 1'b1;
        end else begin
          state_d = WAIT;
          m_rd_d  = 1'b0;
          m_wr_d  = 1'b0;
        end
      end
      WAIT: begin
        if (m_err) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (m_done) begin
          complete_s = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
        m_rd_d  = 1'b0;
        m_wr_d  = 1'b0;
      end
    endcase

    // Writes complete without touching the load data register.
    if (complete_s) begin
      state_d = IDLE;
      m_rd_d  = 1'b0;
      m_wr_d  = 1'b0;
      if (own_data_q) begin
        d_done_d = 1'b1;
        if (!wr_q) begin
          d_rdata_d = m_rdata;
        end else begin
          d_rdata_d = d_rdata_q;
        end
      end else begin
        i_done_d  = 1'b1;
        i_rdata_d = m_rdata;
      end
    end else begin
      i_done_d = 1'b0;
      d_done_d = 1'b0;
    end
  end

  // State and registered-output flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      starve_q   <= 3'd0;
      own_data_q <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      i_rdata_q  <= 16'h0000;
      d_rdata_q  <= 16'h0000;
      m_rd_q     <= 1'b0;
      m_wr_q     <= 1'b0;
      m_dump_q   <= 1'b0;
      i_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
      err_q      <= 1'b0;
      dumped_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      own_data_q <= own_data_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      m_rd_q     <= m_rd_d;
      m_wr_q     <= m_wr_d;
      m_dump_q   <= m_dump_d;
      i_done_q   <= i_done_d;
      d_done_q   <= d_done_d;
      err_q      <= err_d;
      dumped_q   <= dumped_d;
    end
  end

  assign i_rdata = i_rdata_q;
  assign i_done  = i_done_q;
  assign i_stall = i_req & ~i_done_q;
  assign d_rdata = d_rdata_q;
  assign d_done  = d_done_q;
  assign d_stall = d_req_s & ~d_done_q;
  assign m_rd    = m_rd_q;
  assign m_wr    = m_wr_q;
  assign m_dump  = m_dump_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign err     = err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_MAX, default 4, meaning consecutive data grants allowed while an instruction request waits (range 1..7).
REQ-002 The block SHALL have clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have rst  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have i_req  input  1  instruction fetch read request, held high until i_done.
REQ-005 The block SHALL have i_addr  input  16  instruction fetch address.
REQ-006 The block SHALL have i_rdata  output  16  fetched word, valid in the i_done cycle and held until the next i_done.
REQ-007 The block SHALL have i_done / i_stall  output  1 each  fetch completion pulse / fetch stall.
REQ-008 The block SHALL have d_rd / d_wr  input  1 each  data read / write request, held high until d_done.
REQ-009 The block SHALL have d_addr / d_wdata  input  16 each  data address / write data.
REQ-010 The block SHALL have d_rdata  output  16  load word, valid in the d_done cycle and held until the next d_done.
REQ-011 The block SHALL have d_done / d_stall  output  1 each  data completion pulse / data stall.
REQ-012 The block SHALL have m_rd, m_wr, m_dump  output  1 each  to the shared stalling memory: read, write, createdump.
REQ-013 The block SHALL have m_addr / m_wdata  output  16 each  to the shared memory.
REQ-014 The block SHALL have m_rdata  input  16,  m_done / m_stall / m_err  input  1 each  from the shared memory.
REQ-015 The block SHALL have halt  input  1  processor halt; err  output  1  sticky error.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT.
REQ-017 In IDLE with any request, the block SHALL latch owner, op, address and write data, then go to ISSUE; with no request it SHALL stay in IDLE.
REQ-018 Arbitration: data SHALL win over instruction, except when starve_cnt equals STARVE_MAX, in which case instruction SHALL win.
REQ-019 starve_cnt (3 bits, saturating) SHALL increment on each data grant made while i_req is high, and SHALL clear on each instruction grant.
REQ-020 In ISSUE the block SHALL drive m_rd or m_wr together with the latched m_addr/m_wdata.
REQ-021 In ISSUE, if m_stall=1 the block SHALL stay in ISSUE, holding all m_* outputs.
REQ-022 In ISSUE, if m_stall=0 and m_done=1 (hit), the block SHALL complete and return to IDLE.
REQ-023 In ISSUE, if m_stall=0 and m_done=0, the block SHALL go to WAIT.
REQ-024 In WAIT, m_rd and m_wr SHALL be 0 and m_addr/m_wdata SHALL be held.
REQ-025 In WAIT, on m_done=1 the block SHALL complete and return to IDLE.
REQ-026 On completion, the block SHALL capture m_rdata into the owner's rdata register (reads only) and pulse the owner's done for exactly one cycle, registered, in the cycle after m_done.
REQ-027 Minimum latency SHALL be 3 cycles from request seen in IDLE to done: IDLE, then ISSUE with hit, then done.
REQ-028 i_stall SHALL equal i_req & ~i_done; d_stall SHALL equal (d_rd|d_wr) & ~d_done.
REQ-029 Request or operand changes after latching SHALL be ignored until completion.
REQ-030 A request arriving in the done-pulse cycle SHALL be arbitrated normally, since the FSM is already in IDLE.
REQ-031 err SHALL set on m_err=1 during ISSUE or WAIT, or on d_rd&d_wr both high in IDLE (the request is then dropped), and SHALL remain set until reset.
REQ-032 m_dump SHALL pulse for one cycle when halt=1 in IDLE with no request pending, and only once per halt assertion.

Reset
REQ-033 While rst=0, the FSM SHALL be in IDLE, and starve_cnt, err, all done/m_* outputs and the rdata registers SHALL be 0.
REQ-034 Reset mid-transaction SHALL abandon the pending operation with no done pulse; the requester re-requests after release.

Verification
REQ-035 The bench SHALL cover a data read hit: d_rd=1, d_addr=0x0010, m_done in ISSUE with m_rdata=0xBEEF -> d_done after 3 cycles, d_rdata=0xBEEF, m_rd high exactly 1 cycle.
REQ-036 The bench SHALL cover a stalled write: d_wr=1, d_wdata=0x1234, m_stall=1 for 2 cycles, then m_done 3 cycles later -> m_wr held 3 cycles, single d_done, d_stall high throughout until then.
REQ-037 The bench SHALL cover starvation with STARVE_MAX=4 and i_req and data requests continuously high -> 4 data grants, then 1 instruction grant, then starve_cnt=0.
REQ-038 The bench SHALL cover an error: m_err=1 in WAIT -> err=1 persisting after completion; d_rd=d_wr=1 -> err=1 and no memory access.
REQ-039 The bench SHALL cover reset mid-operation: rst low during WAIT -> all outputs 0 immediately (asynchronous), no i_done/d_done.
REQ-040 The bench SHALL cover halt: halt=1 while busy -> no m_dump; on returning to IDLE with no request -> m_dump exactly 1 cycle.
